alu_issue_ctrl: RTL and testbench

- Initiator side of the ALU operand/opcode interface. Accepts one operation request at a time over a valid/ready handshake, drives the registered ALU, and waits the fixed ALU latency.
- Captures the ALU result and status, then returns them on a valid/ready response channel.
- Rejects unsupported opcodes locally without issuing them to the ALU.
- Sits between the decode/execute control and the ALU instance.

---
 rtl/alu_issue_ctrl.sv | 149 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue controller for a registered ALU: accepts one request, waits out the
// ALU latency, captures result/status and returns them on a response channel.
module alu_issue_ctrl #(
  parameter int WIDTH       = 16,
  parameter int ALU_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,

  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic [1:0]       resp_status,
  output logic             resp_err,

  output logic [2:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_in0,
  output logic [WIDTH-1:0] alu_in1,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [1:0]       alu_status,

  output logic [15:0]      op_count,
  output logic [7:0]       err_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int              CNT_W    = 3;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(ALU_LATENCY);

  // Opcodes 000..100 are the only ones the ALU implements.
  function automatic logic op_supported(input logic [2:0] op);
    return op <= 3'b100;
  endfunction

  state_t           state_q;
  logic [CNT_W-1:0] wait_cnt_q;
  logic             req_ready_q;
  logic             resp_valid_q;
  logic [WIDTH-1:0] resp_result_q;
  logic [1:0]       resp_status_q;
  logic             resp_err_q;
  logic [2:0]       alu_opcode_q;
  logic [WIDTH-1:0] alu_in0_q;
  logic [WIDTH-1:0] alu_in1_q;
  logic [15:0]      op_count_q;
  logic [7:0]       err_count_q;

  logic req_fire;
  logic resp_fire;

  assign req_fire  = req_valid && req_ready_q;
  assign resp_fire = resp_valid_q && resp_ready;

  // NOTE: every state register below is updated with <= so all of them see
  // the pre-edge values of each other; a blocking = here would chain updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      wait_cnt_q    <= '0;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_result_q <= '0;
      resp_status_q <= '0;
      resp_err_q    <= 1'b0;
      alu_opcode_q  <= '0;
      alu_in0_q     <= '0;
      alu_in1_q     <= '0;
      op_count_q    <= '0;
      err_count_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_fire) begin
            req_ready_q <= 1'b0;
            if (op_supported(req_op)) begin
              alu_opcode_q <= req_op;
              alu_in0_q    <= req_a;
              alu_in1_q    <= req_b;
              wait_cnt_q   <= LAT_LOAD;
              state_q      <= EXEC;
            end else begin
              resp_result_q <= '0;
              resp_status_q <= '0;
              resp_err_q    <= 1'b1;
              resp_valid_q  <= 1'b1;
              if (err_count_q != 8'hFF) begin
                err_count_q <= err_count_q + 8'd1;
              end
              state_q <= RESP;
            end
          end
        end

        EXEC: begin
          // One extra edge beyond the ALU latency so alu_out is sampled settled.
          if (wait_cnt_q == '0) begin
            resp_result_q <= alu_out;
            resp_status_q <= alu_status;
            resp_err_q    <= 1'b0;
            resp_valid_q  <= 1'b1;
            state_q       <= RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q - 1'b1;
          end
        end

        RESP: begin
          if (resp_fire) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            if (!resp_err_q) begin
              op_count_q <= op_count_q + 16'd1;
            end
            state_q <= IDLE;
          end
        end

        default: begin
          state_q      <= IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_result = resp_result_q;
  assign resp_status = resp_status_q;
  assign resp_err    = resp_err_q;
  assign alu_opcode  = alu_opcode_q;
  assign alu_in0     = alu_in0_q;
  assign alu_in1     = alu_in1_q;
  assign op_count    = op_count_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: a pipelined ALU model, a stimulus process
// that queues hand-computed expected responses, and a monitor that checks them.
module tb_alu_issue_ctrl;

  localparam int W = 16;
  localparam int L = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_op;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         resp_valid;
  logic         resp_ready;
  logic [W-1:0] resp_result;
  logic [1:0]   resp_status;
  logic         resp_err;
  logic [2:0]   alu_opcode;
  logic [W-1:0] alu_in0;
  logic [W-1:0] alu_in1;
  logic [W-1:0] alu_out;
  logic [1:0]   alu_status;
  logic [15:0]  op_count;
  logic [7:0]   err_count;

  alu_issue_ctrl #(.WIDTH(W), .ALU_LATENCY(L)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_result(resp_result),
    .resp_status(resp_status),
    .resp_err   (resp_err),
    .alu_opcode (alu_opcode),
    .alu_in0    (alu_in0),
    .alu_in1    (alu_in1),
    .alu_out    (alu_out),
    .alu_status (alu_status),
    .op_count   (op_count),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  // Registered ALU model with L pipeline stages.
  logic [W-1:0] alu_pipe [L];
  logic [W-1:0] alu_comb;
  always_comb begin
    alu_comb = '0;
    case (alu_opcode)
      3'b000: alu_comb = alu_in0 & alu_in1;
      3'b001: alu_comb = alu_in0 | alu_in1;
      3'b010: alu_comb = alu_in0 ^ alu_in1;
      3'b011: alu_comb = alu_in0 + alu_in1;
      3'b100: alu_comb = alu_in0 - alu_in1;
      default: alu_comb = '0;
    endcase
  end
  always @(posedge clk) begin
    alu_pipe[0] <= alu_comb;
    for (int i = 1; i < L; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign alu_out    = alu_pipe[L-1];
  assign alu_status = {alu_out[W-1], alu_out == '0};

  typedef struct packed {
    logic [W-1:0] result;
    logic [1:0]   status;
    logic         err;
  } resp_t;

  resp_t sb[$];
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare each response on the cycle it is handed off.
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got result 0x%0h, expected no response", resp_result);
      end else begin
        resp_t e;
        e = sb.pop_front();
        check("resp_result", 32'(resp_result), 32'(e.result));
        check("resp_status", 32'(resp_status), 32'(e.status));
        check("resp_err",    32'(resp_err),    32'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic drive_req(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
  endtask

  // Returns at #1 after the accept edge.
  task automatic wait_accept(input string name);
    logic rdy;
    bit   ok;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check({name, "_accept_timeout"}, 32'd0, 32'd1);
  endtask

  // Edge count including the accept edge until resp_valid is seen high.
  task automatic wait_valid(input string name, output int n);
    n = 1;
    while (!resp_valid && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!resp_valid) check({name, "_resp_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic finish_resp;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("resp_valid_drop", 32'(resp_valid), 32'd0);
  endtask

  task automatic do_op(input string name, input logic [2:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic [1:0] es,
                       input logic ee, input int exp_lat);
    int n;
    sb.push_back('{result: er, status: es, err: ee});
    drive_req(op, a, b);
    wait_accept(name);
    req_valid = 1'b0;
    wait_valid(name, n);
    check({name, "_latency"}, 32'(n), 32'(exp_lat));
    finish_resp();
  endtask

  initial begin
    int   n;
    int   exp_ops;
    int   edges;
    bit   bad;

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_op     = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;
    exp_ops    = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready",  32'(req_ready),  32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_result",32'(resp_result),32'd0);
    check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
    check("rst_op_count",   32'(op_count),   32'd0);
    check("rst_err_count",  32'(err_count),  32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    do_op("add_basic", 3'b011, 16'h000A, 16'h0003, 16'h000D, 2'b00, 1'b0, L + 2);
    exp_ops++;
    check("op_count_1", 32'(op_count), 32'(exp_ops));

    do_op("add_wrap", 3'b011, 16'hFFFF, 16'h0002, 16'h0001, 2'b00, 1'b0, L + 2);
    exp_ops++;
    do_op("sub_zero", 3'b100, 16'h0005, 16'h0005, 16'h0000, 2'b01, 1'b0, L + 2);
    exp_ops++;

    // ADD with negative result, then XOR presented immediately and held.
    sb.push_back('{result: 16'hFFFE, status: 2'b10, err: 1'b0});
    sb.push_back('{result: 16'h000A, status: 2'b00, err: 1'b0});
    drive_req(3'b011, 16'hFFFE, 16'h0000);
    wait_accept("add_neg");
    drive_req(3'b010, 16'h000C, 16'h0006);
    edges = 0;
    bad   = 0;
    for (int i = 0; i < 40; i++) begin
      logic rdy;
      @(negedge clk);
      rdy = req_ready;
      if (rdy && resp_valid) bad = 1;
      @(posedge clk);
      #1;
      edges++;
      if (rdy) break;
    end
    req_valid = 1'b0;
    check("b2b_ready_while_busy", 32'(bad), 32'd0);
    check("b2b_accept_gap", 32'(edges), 32'(L + 3));
    wait_valid("xor_b2b", n);
    check("xor_b2b_latency", 32'(n), 32'(L + 2));
    finish_resp();
    exp_ops += 2;
    check("op_count_b2b", 32'(op_count), 32'(exp_ops));

    do_op("bad_op7", 3'b111, 16'h1234, 16'h5678, 16'h0000, 2'b00, 1'b1, 1);
    check("bad_alu_opcode", 32'(alu_opcode), 32'd2);
    check("bad_alu_in0",    32'(alu_in0),    32'h000C);
    check("bad_alu_in1",    32'(alu_in1),    32'h0006);
    check("bad_err_count",  32'(err_count),  32'd1);
    check("bad_op_count",   32'(op_count),   32'(exp_ops));

    // Backpressure: consumer stalls for 4 cycles.
    resp_ready = 1'b0;
    sb.push_back('{result: 16'h0009, status: 2'b00, err: 1'b0});
    drive_req(3'b001, 16'h0008, 16'h0001);
    wait_accept("or_bp");
    req_valid = 1'b0;
    wait_valid("or_bp", n);
    check("or_bp_latency", 32'(n), 32'(L + 2));
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!resp_valid || resp_result !== 16'h0009 || req_ready) bad = 1;
    end
    check("bp_hold_stable", 32'(bad), 32'd0);
    @(posedge clk);
    #1;
    finish_resp();
    exp_ops++;
    check("op_count_bp", 32'(op_count), 32'(exp_ops));

    // Reset while SUB 0-2 is executing; no response may follow.
    drive_req(3'b100, 16'h0000, 16'h0002);
    wait_accept("sub_rst");
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_req_ready", 32'(req_ready),  32'd1);
    check("mid_rst_resp_valid",32'(resp_valid), 32'd0);
    check("mid_rst_alu_in1",   32'(alu_in1),    32'd0);
    check("mid_rst_op_count",  32'(op_count),   32'd0);
    check("mid_rst_err_count", 32'(err_count),  32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) bad = 1;
    end
    check("post_rst_no_resp", 32'(bad), 32'd0);
    @(posedge clk);
    #1;
    exp_ops = 0;
    do_op("add_after_rst", 3'b011, 16'h0001, 16'h0001, 16'h0002, 2'b00, 1'b0, L + 2);
    exp_ops++;
    check("op_count_after_rst", 32'(op_count), 32'(exp_ops));

    repeat (2) @(posedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
